axis_frame_trailer_inserter: RTL
================================

Name: axis_frame_trailer_inserter

Overview:
- Generalised successor to the frame header adder in the streaming datapath.
- Forwards a configurable number of payload beats from the data AXI-Stream, then a configurable number of metadata beats from the meta stream, then one frame-counter beat carrying TLAST.
- Full AXI-Stream backpressure on all three interfaces.
- Sits between the frame source / metadata generator and the output DMA / MAC stream.

Parameters:
- DW, 128, data width of all stream tdata buses.
- BEAT_CNT_W, 16, width of the payload-beat counter and of cfg_payload_beats.
- META_MAX, 8, maximum metadata beats per frame; META_CNT_W = clog2(META_MAX+1).
- FC_W, 32, frame-counter width; must satisfy FC_W <= DW.
- TLAST_PER_PACKET, 0, when 1 also assert TLAST on every PKT_BEATS-th payload beat.
- PKT_BEATS, 4, payload beats per packet; used only when TLAST_PER_PACKET=1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_payload_beats  in  BEAT_CNT_W  payload beats per frame; 0 is treated as 1.
- cfg_meta_beats  in  META_CNT_W  metadata beats per frame; values above META_MAX are clamped to META_MAX.
- s_data_tdata / s_data_tvalid / s_data_tready  in/in/out  DW/1/1  payload stream.
- s_meta_tdata / s_meta_tvalid / s_meta_tready  in/in/out  DW/1/1  metadata stream.
- m_tdata / m_tvalid / m_tready / m_tlast  out/out/in/out  DW/1/1/1  output stream.
- frame_done  out  1  one-cycle pulse when the counter beat is accepted.
- frame_count  out  FC_W  number of completed frames.

Behaviour:
- States: DATA, META, COUNT; reset state is DATA.
- Reset values: counters = 0, frame_count = 0, frame_done = 0, m_tvalid = 0, m_tlast = 0, both s_*_tready = 0.
- Config latch: cfg_payload_beats and cfg_meta_beats are latched when the first payload beat of a frame is accepted (including its zero-fix and clamp); mid-frame config changes have no effect.
- Datapath: zero-latency combinational pass-through, no internal buffering.
  - DATA: m_tdata = s_data_tdata; m_tvalid = s_data_tvalid; s_data_tready = m_tready.
  - META: m_tdata = s_meta_tdata; m_tvalid = s_meta_tvalid; s_meta_tready = m_tready.
  - COUNT: m_tdata = zero-extended frame_count; m_tvalid = 1.
  - The stream not selected by the current state has tready = 0.
- A beat counts only on m_tvalid & m_tready.
- Transitions:
  - DATA -> META on acceptance of the final payload beat; DATA -> COUNT directly if the latched meta count is 0.
  - META -> COUNT on acceptance of the final metadata beat.
  - COUNT -> DATA on acceptance of the counter beat.
- m_tlast:
  - Always 1 on the counter beat.
  - When TLAST_PER_PACKET=1, also 1 on every payload beat whose 1-based index within the frame is a multiple of PKT_BEATS, and on the final payload beat.
  - 0 otherwise.
- On counter-beat acceptance: frame_count increments modulo 2^FC_W (wraps to 0) and frame_done pulses in the following cycle. The counter beat carries the pre-increment value, so the first frame carries 0.
- Stall rule: while m_tvalid=1 and m_tready=0, m_tdata and m_tlast stay stable as long as the selected source holds its data. The counter beat is internally stable.
- Reset mid-frame: returns to DATA immediately; partial frame discarded; frame_count cleared.
- Simultaneous reset and handshake: reset wins and the beat is not counted.

Decomposition:
- Shared package axis_framer_pkg: state encoding constants (ST_DATA, ST_META, ST_COUNT) and the clog2 helper.
- One sub-module is natural: beat_counter (loadable terminal-count counter with enable, last flag and clear), instantiated for the payload and metadata counts.

Test Plan:
- cfg_payload_beats=4, cfg_meta_beats=2, m_tready=1, continuous valid -> 7 beats: D0..D3, M0, M1, then 0x0 with tlast. A second frame ends with 0x1; frame_done pulses twice.
- Same config, m_tready toggling 1010… and s_data_tvalid gapped -> identical 7-beat sequence; no duplicated or dropped beats; tdata stable during stalls.
- cfg_meta_beats=0, cfg_payload_beats=3 -> D0..D2 then counter beat with tlast; s_meta_tready stays 0 throughout.
- TLAST_PER_PACKET=1, PKT_BEATS=4, cfg_payload_beats=10, meta 1 -> tlast on payload beats 4, 8 and 10, then on the counter beat.
- cfg_payload_beats=0 -> exactly one payload beat per frame. FC_W=4 over 17 frames -> counter beats 0..15 then 0.
- Assert reset after payload beat 2 of a 4-beat frame -> the next frame starts from D0, and its counter beat is 0.

Source files
------------

// File: rtl/axis_frame_trailer_inserter_pkg.sv
// Shared definitions for the frame trailer inserter: FSM state encoding and a width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axis_framer_pkg;

    // Frame phases: payload beats, metadata beats, then the frame-counter beat.
    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_META  = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    // Ceiling log2 for sizing counters; clog2(1) = 0, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_frame_trailer_inserter_if.sv
// AXI-Stream bundle used for the payload, metadata and output streams.
// Latency: n/a (wires only).
// Backpressure: carries tready from slave to master.
interface axis_frame_trailer_inserter_if #(
    parameter int DW = 128
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_frame_trailer_inserter_beat_counter.sv
// Beat counter with a terminal count captured on the first counted beat of each run.
// Latency: last flag is combinational on the current count; count updates one cycle after en.
// Backpressure: none; en must already be qualified by the caller's handshake.
module beat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] term_in,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] term_q;
    logic [W-1:0] term_eff;
    logic         first;

    // The terminal count is taken live on the first beat, from the latch afterwards.
    always_comb begin
        first    = (cnt_q == '0);
        term_eff = first ? term_in : term_q;
        last     = ((cnt_q + W'(1)) == term_eff);
        count    = cnt_q;
    end

    // Advance on each counted beat, wrapping to zero after the terminal beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else if (en) begin
            if (first) begin
                term_q <= term_in;
            end
            if (last) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_frame_trailer_inserter.sv
// Emits payload beats, then metadata beats, then a frame-counter beat with TLAST, per frame.
// Latency: zero-cycle combinational pass-through; no internal buffering.
// Backpressure: m_tready passes straight to whichever source the current phase selects.
module axis_frame_trailer_inserter
    import axis_framer_pkg::*;
#(
    parameter int DW               = 128,
    parameter int BEAT_CNT_W       = 16,
    parameter int META_MAX         = 8,
    parameter int META_CNT_W       = clog2(META_MAX + 1),
    parameter int FC_W             = 32,
    parameter int TLAST_PER_PACKET = 0,
    parameter int PKT_BEATS        = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BEAT_CNT_W-1:0]          cfg_payload_beats,
    input  logic [META_CNT_W-1:0]          cfg_meta_beats,
    axis_frame_trailer_inserter_if.slave   s_data,
    axis_frame_trailer_inserter_if.slave   s_meta,
    axis_frame_trailer_inserter_if.master  m,
    output logic                           frame_done,
    output logic [FC_W-1:0]                frame_count
);

    localparam int PKT_W = clog2(PKT_BEATS + 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [META_CNT_W-1:0]   meta_cfg_q;
    logic [META_CNT_W-1:0]   meta_clamped;
    logic [META_CNT_W-1:0]   meta_eff;
    logic [BEAT_CNT_W-1:0]   pay_term;
    logic [BEAT_CNT_W-1:0]   pay_cnt;
    logic                    pay_last;
    logic                    pay_first;
    logic [META_CNT_W-1:0]   meta_cnt;
    logic                    meta_last;
    logic [PKT_W-1:0]        pkt_q;
    logic                    pkt_last;
    logic                    m_hs;
    logic                    data_beat;
    logic                    meta_beat;
    logic                    count_beat;

    // Config fix-ups, beat qualification and the meta count seen at the payload/meta boundary.
    always_comb begin
        pay_term     = (cfg_payload_beats == '0) ? BEAT_CNT_W'(1) : cfg_payload_beats;
        meta_clamped = (cfg_meta_beats > META_CNT_W'(META_MAX)) ? META_CNT_W'(META_MAX)
                                                                : cfg_meta_beats;
        pay_first    = (pay_cnt == '0);
        meta_eff     = pay_first ? meta_clamped : meta_cfg_q;
        pkt_last     = (pkt_q == PKT_W'(PKT_BEATS - 1));
        m_hs         = m.tvalid & m.tready;
        data_beat    = m_hs & (state_q == ST_DATA);
        meta_beat    = m_hs & (state_q == ST_META);
        count_beat   = m_hs & (state_q == ST_COUNT);
    end

    beat_counter #(.W(BEAT_CNT_W)) u_pay_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (data_beat),
        .term_in (pay_term),
        .count   (pay_cnt),
        .last    (pay_last)
    );

    beat_counter #(.W(META_CNT_W)) u_meta_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (meta_beat),
        .term_in (meta_cfg_q),
        .count   (meta_cnt),
        .last    (meta_last)
    );

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase sequencing; a frame with no metadata goes straight to the counter beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DATA: begin
                if (data_beat && pay_last) begin
                    state_d = (meta_eff == '0) ? ST_COUNT : ST_META;
                end
            end
            ST_META: begin
                if (meta_beat && meta_last) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (count_beat) begin
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    // Output mux: route the selected source through and hold the other source off.
    always_comb begin
        m.tdata       = '0;
        m.tvalid      = 1'b0;
        m.tlast       = 1'b0;
        s_data.tready = 1'b0;
        s_meta.tready = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_DATA: begin
                    m.tdata       = s_data.tdata;
                    m.tvalid      = s_data.tvalid;
                    m.tlast       = (TLAST_PER_PACKET != 0) && (pkt_last || pay_last);
                    s_data.tready = m.tready;
                end
                ST_META: begin
                    m.tdata       = s_meta.tdata;
                    m.tvalid      = s_meta.tvalid;
                    s_meta.tready = m.tready;
                end
                ST_COUNT: begin
                    m.tdata  = DW'(frame_count);
                    m.tvalid = 1'b1;
                    m.tlast  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Capture the metadata count with the first payload beat so mid-frame edits are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_cfg_q <= '0;
        end else if (data_beat && pay_first) begin
            meta_cfg_q <= meta_clamped;
        end
    end

    // Position within the current packet; restarts at every frame's final payload beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q <= '0;
        end else if (data_beat) begin
            if (pay_last || pkt_last) begin
                pkt_q <= '0;
            end else begin
                pkt_q <= pkt_q + PKT_W'(1);
            end
        end
    end

    // Completed-frame count and done pulse, both following acceptance of the counter beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= count_beat;
            if (count_beat) begin
                frame_count <= frame_count + FC_W'(1);
            end
        end
    end

endmodule
